// File: rtl/wb_ctrl.sv
// Writeback sequencer (IDLE -> RUN -> FLUSH -> DONE) plus BRAM32k port arbiter giving writeback priority over loader reads.
// Optional WB_CTRL_PERF_EN adds rd_stall_cnt, a saturating count of cycles a loader read was blocked by a write.
`ifndef Layer1
`define Layer1 4'd1
`endif

module wb_ctrl #(
    parameter int ADDR_W    = 12,
    parameter int FLUSH_CYC = 3,
    parameter int TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        Layer,
    input  logic [ADDR_W-1:0] num_words,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr_1,
    input  logic [ADDR_W-1:0] wr_addr_2,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              wb_en,
    output logic              FinishWB,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr_1,
    output logic [ADDR_W-1:0] bram_addr_2,
    output logic              rd_grant,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] wr_count
`ifdef WB_CTRL_PERF_EN
    ,
    output logic [15:0]       rd_stall_cnt
`endif
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam int FLUSH_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   count_reg, count_next;
    logic [ADDR_W-1:0]   target_reg, target_next;
    logic [TIMER_W-1:0]  timer_reg, timer_next;
    logic [FLUSH_W-1:0]  flush_reg, flush_next;
    logic                err_next;
    logic                accept_start;

    logic wb_en_reg, finish_reg, done_reg, err_reg, busy_reg;

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        target_next  = target_reg;
        timer_next   = timer_reg;
        flush_next   = flush_reg;
        err_next     = 1'b0;
        accept_start = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (Layer == `Layer1) begin
                        accept_start = 1'b1;
                        count_next   = '0;
                        timer_next   = '0;
                        flush_next   = '0;
                        target_next  = num_words;
                        state_next   = (num_words != '0) ? ST_RUN : ST_DONE;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (wr_req) begin
                    count_next = count_reg + 1'b1;
                    timer_next = '0;
                    if (count_reg + 1'b1 == target_reg) begin
                        flush_next = '0;
                        state_next = ST_FLUSH;
                    end
                end else if (timer_reg == TIMER_W'(TIMEOUT - 1)) begin
                    // Stall watchdog: abandon the layer rather than hang the pipeline.
                    err_next   = 1'b1;
                    timer_next = '0;
                    state_next = ST_IDLE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            ST_FLUSH: begin
                // Late commits flushed by FinishWB still land in BRAM and are counted.
                if (wr_req) begin
                    count_next = count_reg + 1'b1;
                end
                if (flush_reg == FLUSH_W'(FLUSH_CYC - 1)) begin
                    state_next = ST_DONE;
                end else begin
                    flush_next = flush_reg + 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            count_reg  <= '0;
            target_reg <= '0;
            timer_reg  <= '0;
            flush_reg  <= '0;
            wb_en_reg  <= 1'b0;
            finish_reg <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            target_reg <= target_next;
            timer_reg  <= timer_next;
            flush_reg  <= flush_next;
            // wb_en drops together with the err pulse on a timeout abort.
            wb_en_reg  <= (state_reg == ST_RUN) && (state_next == ST_RUN);
            finish_reg <= (state_reg == ST_FLUSH);
            done_reg   <= (state_reg == ST_DONE);
            err_reg    <= err_next;
            busy_reg   <= (state_reg != ST_IDLE);
        end
    end

    assign wb_en    = wb_en_reg;
    assign FinishWB = finish_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign busy     = busy_reg;
    assign wr_count = count_reg;

    always_comb begin
        bram_we     = 1'b0;
        bram_addr_1 = wr_addr_1;
        bram_addr_2 = wr_addr_2;
        rd_grant    = 1'b0;
        if (wr_req) begin
            bram_we = 1'b1;
        end else if (rd_req) begin
            bram_addr_1 = rd_addr;
            bram_addr_2 = rd_addr;
            rd_grant    = 1'b1;
        end
    end

`ifdef WB_CTRL_PERF_EN
    logic [15:0] stall_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_reg <= '0;
        end else if (accept_start) begin
            stall_reg <= '0;
        end else if (rd_req && !rd_grant && (stall_reg != 16'hFFFF)) begin
            stall_reg <= stall_reg + 16'd1;
        end
    end

    assign rd_stall_cnt = stall_reg;
`endif

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed self-checking bench for wb_ctrl: reset, normal layer, bad layer, zero words, arbiter, timeout.
`ifndef Layer1
`define Layer1 4'd1
`endif

module tb_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  Layer;
    logic [11:0] num_words;
    logic        wr_req;
    logic [11:0] wr_addr_1;
    logic [11:0] wr_addr_2;
    logic        rd_req;
    logic [11:0] rd_addr;
    logic        wb_en;
    logic        FinishWB;
    logic        bram_we;
    logic [11:0] bram_addr_1;
    logic [11:0] bram_addr_2;
    logic        rd_grant;
    logic        busy;
    logic        done;
    logic        err;
    logic [11:0] wr_count;
`ifdef WB_CTRL_PERF_EN
    logic [15:0] rd_stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_ctrl #(.ADDR_W(12), .FLUSH_CYC(3), .TIMEOUT(1024)) dut (
        .clk(clk), .rst(rst), .start(start), .Layer(Layer), .num_words(num_words),
        .wr_req(wr_req), .wr_addr_1(wr_addr_1), .wr_addr_2(wr_addr_2),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .wb_en(wb_en), .FinishWB(FinishWB), .bram_we(bram_we),
        .bram_addr_1(bram_addr_1), .bram_addr_2(bram_addr_2), .rd_grant(rd_grant),
        .busy(busy), .done(done), .err(err), .wr_count(wr_count)
`ifdef WB_CTRL_PERF_EN
        , .rd_stall_cnt(rd_stall_cnt)
`endif
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] l, input logic [11:0] n);
        start = 1'b1;
        Layer = l;
        num_words = n;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] v;
        #1;
        v = {wb_en, FinishWB, done, err, busy, (wr_count != 12'd0)};
        checks++;
        if (v !== 6'b0) begin
            failures++;
            $display("FAIL reset_state got=%b want=000000", v);
        end
        #12 rst = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_run();
        logic [5:0] v;
        do_start(`Layer1, 12'd10);
        tick();
        checks++;
        if (wb_en !== 1'b1) begin
            failures++;
            $display("FAIL midrun_wb_en got=%b want=1", wb_en);
        end
        wr_req = 1'b1;
        repeat (3) tick();
        wr_req = 1'b0;
        checks++;
        if (wr_count !== 12'd3) begin
            failures++;
            $display("FAIL midrun_count got=%0d want=3", wr_count);
        end
        rst = 1'b0;
        #1;
        v = {wb_en, FinishWB, done, err, busy, (wr_count != 12'd0)};
        checks++;
        if (v !== 6'b0) begin
            failures++;
            $display("FAIL midrun_reset_outputs got=%b want=000000", v);
        end
        #2 rst = 1'b1;
        tick();
        do_start(`Layer1, 12'd0);
        tick();
        checks++;
        if ({done, busy} !== 2'b11) begin
            failures++;
            $display("FAIL restart_after_reset done_busy=%b want=11", {done, busy});
        end
        tick();
    endtask

    task automatic test_normal_layer();
        int sent = 0;
        int fin_cnt = 0;
        int done_cnt = 0;
        int err_cnt = 0;
        int overlap = 0;
        int first_wb = -1;
        logic done_busy = 1'b1;
        do_start(`Layer1, 12'd5);
        for (int i = 0; i < 30; i++) begin
            if (FinishWB) fin_cnt++;
            if (done) begin
                done_cnt++;
                done_busy = done_busy & busy;
            end
            if (err) err_cnt++;
            if (wb_en && FinishWB) overlap++;
            if (wb_en && first_wb < 0) first_wb = i;
            start = 1'b0;
            if (wb_en && sent < 5) begin
                wr_req = 1'b1;
                wr_addr_1 = 12'(sent);
                wr_addr_2 = 12'(sent + 12'h100);
                sent++;
                // A start while busy must be ignored (no err, no restart).
                if (sent == 2) begin
                    start = 1'b1;
                    Layer = 4'd3;
                end
            end else begin
                wr_req = 1'b0;
            end
            tick();
        end
        checks++;
        if (first_wb != 1) begin
            failures++;
            $display("FAIL normal_wb_en_latency got=%0d want=1", first_wb);
        end
        checks++;
        if (fin_cnt != 3) begin
            failures++;
            $display("FAIL normal_finishwb_cycles got=%0d want=3", fin_cnt);
        end
        checks++;
        if (done_cnt != 1 || done_busy !== 1'b1) begin
            failures++;
            $display("FAIL normal_done_pulse got=%0d busy=%b want=1 busy=1", done_cnt, done_busy);
        end
        checks++;
        if (wr_count !== 12'd5) begin
            failures++;
            $display("FAIL normal_wr_count got=%0d want=5", wr_count);
        end
        checks++;
        if (err_cnt != 0 || overlap != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL normal_misc err=%0d overlap=%0d busy=%b want=0 0 0", err_cnt, overlap, busy);
        end
    endtask

    task automatic test_bad_layer();
        int wb_seen = 0;
        do_start(4'd3, 12'd5);
        checks++;
        if ({err, busy, wb_en} !== 3'b100) begin
            failures++;
            $display("FAIL badlayer_err err_busy_wben=%b want=100", {err, busy, wb_en});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (err || busy || wb_en) wb_seen++;
        end
        checks++;
        if (wb_seen != 0) begin
            failures++;
            $display("FAIL badlayer_after active_cycles=%0d want=0", wb_seen);
        end
    endtask

    task automatic test_zero_words();
        logic [3:0] done_hist;
        int active = 0;
        do_start(`Layer1, 12'd0);
        done_hist[0] = done;
        for (int i = 1; i < 4; i++) begin
            tick();
            done_hist[i] = done;
            if (wb_en || FinishWB) active++;
        end
        checks++;
        if (done_hist !== 4'b0010) begin
            failures++;
            $display("FAIL zero_words_done history=%b want=0010", done_hist);
        end
        checks++;
        if (active != 0) begin
            failures++;
            $display("FAIL zero_words_wb_en active_cycles=%0d want=0", active);
        end
    endtask

    task automatic test_arbiter();
        wr_req = 1'b1;
        rd_req = 1'b1;
        wr_addr_1 = 12'h010;
        wr_addr_2 = 12'h123;
        rd_addr = 12'h200;
        #1;
        checks++;
        if ({bram_we, rd_grant} !== 2'b10 || bram_addr_1 !== 12'h010 || bram_addr_2 !== 12'h123) begin
            failures++;
            $display("FAIL arb_write_wins we_grant=%b a1=%h a2=%h want=10 010 123",
                     {bram_we, rd_grant}, bram_addr_1, bram_addr_2);
        end
        tick();
        wr_req = 1'b0;
        #1;
        checks++;
        if ({bram_we, rd_grant} !== 2'b01 || bram_addr_1 !== 12'h200 || bram_addr_2 !== 12'h200) begin
            failures++;
            $display("FAIL arb_read_grant we_grant=%b a1=%h a2=%h want=01 200 200",
                     {bram_we, rd_grant}, bram_addr_1, bram_addr_2);
        end
        rd_req = 1'b0;
        #1;
        checks++;
        if ({bram_we, rd_grant} !== 2'b00 || bram_addr_1 !== 12'h010 || bram_addr_2 !== 12'h123) begin
            failures++;
            $display("FAIL arb_idle we_grant=%b a1=%h a2=%h want=00 010 123",
                     {bram_we, rd_grant}, bram_addr_1, bram_addr_2);
        end
        tick();
`ifdef WB_CTRL_PERF_EN
        wr_req = 1'b1;
        rd_req = 1'b1;
        repeat (3) tick();
        wr_req = 1'b0;
        rd_req = 1'b0;
        tick();
        checks++;
        if (rd_stall_cnt !== 16'd4) begin
            failures++;
            $display("FAIL perf_stall_cnt got=%0d want=4", rd_stall_cnt);
        end
`endif
    endtask

    task automatic test_timeout();
        int n = 0;
        logic wb_mid = 1'b0;
        logic wb_at_err = 1'b1;
        do_start(`Layer1, 12'd4);
        for (int i = 1; i <= 1100; i++) begin
            tick();
            if (i == 5) wb_mid = wb_en;
            if (err) begin
                n = i;
                wb_at_err = wb_en;
                break;
            end
        end
        checks++;
        if (n != 1024) begin
            failures++;
            $display("FAIL timeout_cycles got=%0d want=1024", n);
        end
        checks++;
        if (wb_mid !== 1'b1 || wb_at_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_wb_en mid=%b at_err=%b want=1 0", wb_mid, wb_at_err);
        end
        tick();
        checks++;
        if ({err, busy, wb_en} !== 3'b000) begin
            failures++;
            $display("FAIL timeout_idle err_busy_wben=%b want=000", {err, busy, wb_en});
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        Layer = 4'd0;
        num_words = 12'd0;
        wr_req = 1'b0;
        wr_addr_1 = 12'd0;
        wr_addr_2 = 12'd0;
        rd_req = 1'b0;
        rd_addr = 12'd0;
        test_reset();
        test_reset_mid_run();
        test_normal_layer();
        test_bad_layer();
        test_zero_words();
        test_timeout();
        test_arbiter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
